eth_rx_fcs_check: RTL

ETH_RX_FCS_CHECK -- requirements
Module: eth_rx_fcs_check

---
 rtl/eth_rx_fcs_check.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/eth_rx_fcs_check.sv
// Ethernet receive FCS checker: validates CRC-32 and frame length, strips the
// 4 FCS bytes through a delay line and reports per-frame status.
module eth_rx_fcs_check #(
    parameter int pMIN_BYTES = 64,
    parameter int pMAX_BYTES = 1518
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        In_Valid,
    input  logic [7:0]  In_Data,
    input  logic        In_Sof,
    input  logic        In_Eof,
    output logic        Out_Valid,
    output logic [7:0]  Out_Data,
    output logic        Out_Sof,
    output logic        Out_Eof,
    output logic        Frame_Done,
    output logic        Frame_Good,
    output logic [15:0] Frame_Len,
    output logic [15:0] Err_Cnt
);

    typedef enum logic [1:0] {IDLE, FILL, PASS} state_t;

    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [15:0] MIN_LEN     = 16'(pMIN_BYTES);
    localparam logic [15:0] MAX_LEN     = 16'(pMAX_BYTES);

    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    state_t          state_q, state_d;
    logic [31:0]     crc_q, crc_d;
    logic [15:0]     len_q, len_d;
    logic [2:0]      fill_q, fill_d;
    logic [3:0][7:0] dl_q, dl_d;
    logic            first_q, first_d;
    logic            out_valid_q, out_valid_d;
    logic [7:0]      out_data_q, out_data_d;
    logic            out_sof_q, out_sof_d;
    logic            out_eof_q, out_eof_d;
    logic            done_q, done_d;
    logic            good_q, good_d;
    logic [15:0]     flen_q, flen_d;
    logic [15:0]     err_q, err_d;
    logic            pend_q, pend_d;
    logic            pend_good_q, pend_good_d;
    logic [15:0]     pend_len_q, pend_len_d;

    logic [31:0]     crc_nx;
    logic [15:0]     len_inc;
    logic            ev_a, ev_b, ev_b_good;
    logic [15:0]     ev_b_len;
    logic            em_valid, em_good;
    logic [15:0]     em_len;

    // ev_a is an abort caused by a new In_Sof mid-frame, ev_b a frame ending on
    // In_Eof; when both occur the second one waits a cycle in the pending slot.
    always_comb begin
        state_d     = state_q;
        crc_d       = crc_q;
        len_d       = len_q;
        fill_d      = fill_q;
        dl_d        = dl_q;
        first_d     = first_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_sof_d   = 1'b0;
        out_eof_d   = 1'b0;
        done_d      = 1'b0;
        good_d      = good_q;
        flen_d      = flen_q;
        err_d       = err_q;
        pend_d      = 1'b0;
        pend_good_d = pend_good_q;
        pend_len_d  = pend_len_q;
        ev_a        = 1'b0;
        ev_b        = 1'b0;
        ev_b_good   = 1'b0;
        ev_b_len    = 16'h0;
        em_valid    = 1'b0;
        em_good     = 1'b0;
        em_len      = 16'h0;

        crc_nx  = crc_byte(In_Sof ? CRC_INIT : crc_q, In_Data);
        len_inc = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;

        if (In_Valid) begin
            if (In_Sof) begin
                ev_a    = (state_q != IDLE);
                crc_d   = crc_nx;
                len_d   = 16'd1;
                dl_d    = '0;
                dl_d[0] = In_Data;
                fill_d  = 3'd1;
                first_d = 1'b1;
                if (In_Eof) begin
                    ev_b     = 1'b1;
                    ev_b_len = 16'd1;
                    state_d  = IDLE;
                end else begin
                    state_d  = FILL;
                end
            end else if (state_q != IDLE) begin
                crc_d = crc_nx;
                len_d = len_inc;
                dl_d  = {dl_q[2:0], In_Data};
                if (state_q == PASS) begin
                    out_valid_d = 1'b1;
                    out_data_d  = dl_q[3];
                    out_sof_d   = first_q;
                    out_eof_d   = In_Eof;
                    first_d     = 1'b0;
                end else begin
                    fill_d = fill_q + 3'd1;
                    if (fill_q == 3'd3) begin
                        state_d = PASS;
                    end
                end
                if (In_Eof) begin
                    ev_b      = 1'b1;
                    ev_b_len  = len_inc;
                    ev_b_good = (state_q == PASS) && (crc_nx == CRC_RESIDUE) &&
                                (len_inc >= MIN_LEN) && (len_inc <= MAX_LEN);
                    state_d   = IDLE;
                end
            end
        end

        if (pend_q) begin
            em_valid    = 1'b1;
            em_good     = pend_good_q;
            em_len      = pend_len_q;
            pend_d      = ev_b;
            pend_good_d = ev_b_good;
            pend_len_d  = ev_b_len;
        end else if (ev_a) begin
            em_valid    = 1'b1;
            em_good     = 1'b0;
            em_len      = len_q;
            pend_d      = ev_b;
            pend_good_d = ev_b_good;
            pend_len_d  = ev_b_len;
        end else if (ev_b) begin
            em_valid    = 1'b1;
            em_good     = ev_b_good;
            em_len      = ev_b_len;
        end

        if (em_valid) begin
            done_d = 1'b1;
            good_d = em_good;
            flen_d = em_len;
            if (!em_good && err_q != 16'hFFFF) begin
                err_d = err_q + 16'd1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= IDLE;
            crc_q       <= CRC_INIT;
            len_q       <= 16'h0;
            fill_q      <= 3'd0;
            dl_q        <= '0;
            first_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            done_q      <= 1'b0;
            good_q      <= 1'b0;
            flen_q      <= 16'h0;
            err_q       <= 16'h0;
            pend_q      <= 1'b0;
            pend_good_q <= 1'b0;
            pend_len_q  <= 16'h0;
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            len_q       <= len_d;
            fill_q      <= fill_d;
            dl_q        <= dl_d;
            first_q     <= first_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sof_q   <= out_sof_d;
            out_eof_q   <= out_eof_d;
            done_q      <= done_d;
            good_q      <= good_d;
            flen_q      <= flen_d;
            err_q       <= err_d;
            pend_q      <= pend_d;
            pend_good_q <= pend_good_d;
            pend_len_q  <= pend_len_d;
        end
    end

    assign Out_Valid  = out_valid_q;
    assign Out_Data   = out_data_q;
    assign Out_Sof    = out_sof_q;
    assign Out_Eof    = out_eof_q;
    assign Frame_Done = done_q;
    assign Frame_Good = good_q;
    assign Frame_Len  = flen_q;
    assign Err_Cnt    = err_q;

endmodule
